mem_ss_rst_cal_seq: RTL and testbench
=====================================

Name: mem_ss_rst_cal_seq

Overview:
Hardware sequencer that issues a reset request to the memory subsystem and waits for the reset acknowledge. It then supervises EMIF calibration across NUM_CH channels and publishes per-channel calibration status plus aggregate ready/fail flags to the CSR/DFH status logic. It replaces software polling of calibration status with a timed, debounced, retryable on-chip sequence. It sits between the FME/port reset controller and mem_ss_top.

Parameters:
NUM_CH, 4, number of EMIF channels supervised (1..8)
RST_PULSE_CYC, 16, minimum cycles mem_ss_rst_req is held high
ACK_TIMEOUT, 1024, max cycles to wait for each reset-ack edge
CAL_TIMEOUT, 1048576, max cycles to wait for masked calibration success
STABLE_CYC, 3, consecutive cycles masked success must hold before DONE
MAX_RETRY, 2, retries after timeout or calibration failure (with MEM_SS_CAL_RETRY_EN)
TMR_W, $clog2(CAL_TIMEOUT+1), shared timer width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  single-cycle pulse: begin sequence; ignored while busy
ch_mask  in  NUM_CH  channels that must calibrate (capability mask); sampled on accepted start
mem_ss_rst_req  out  1  reset request to memory subsystem
mem_ss_rst_ack_n  in  1  active-low ack; low = reset taken
mem_ss_cal_success  in  NUM_CH  per-channel calibration pass level
mem_ss_cal_fail  in  NUM_CH  per-channel calibration fail level
busy  out  1  sequence in progress
ready  out  1  all masked channels calibrated and stable
fail  out  1  sequence terminated in error
cal_status  out  NUM_CH  registered success AND latched mask
fail_code  out  2  0 none, 1 ack timeout, 2 cal timeout, 3 cal fail
retry_cnt  out  2  retries consumed

Behaviour:
- Async reset: state=IDLE; all outputs 0; timer 0; latched mask 0.
- IDLE:
  - On start: latch ch_mask, clear ready/fail/fail_code/retry_cnt, set busy, go to RST_ASSERT next cycle.
  - If the latched mask is all zero: go directly to DONE, with ready=1 one cycle after start.
- RST_ASSERT:
  - mem_ss_rst_req=1; timer counts up.
  - Once timer>=RST_PULSE_CYC-1 and ack_n==0: go to RST_RELEASE.
  - If timer reaches ACK_TIMEOUT without ack_n low: FAIL with code 1.
- RST_RELEASE:
  - mem_ss_rst_req=0; timer reset on entry.
  - Wait for ack_n==1: go to CAL_WAIT.
  - Timeout ACK_TIMEOUT: FAIL with code 1.
- CAL_WAIT:
  - Timer reset on entry.
  - (cal_fail & mask)!=0: FAIL code 3; fail takes priority over success in the same cycle.
  - (cal_success & mask)==mask: go to CAL_STABLE with stable counter =1.
  - Timer reaching CAL_TIMEOUT: FAIL code 2.
- CAL_STABLE:
  - Stable counter increments while the condition holds.
  - Reaches STABLE_CYC: DONE.
  - Condition drops: back to CAL_WAIT; timer NOT reset, so the total budget holds.
  - Fail bit: FAIL code 3.
- DONE: ready=1, busy=0; hold until the next start, which re-runs the full sequence.
- FAIL: fail=1, busy=0, mem_ss_rst_req=0; hold until the next start.
- cal_status is registered every cycle from mem_ss_cal_success & latched mask, in all states.
- Timer saturates and never wraps.
- start while busy is ignored, with no effect on state.
- Async rst mid-sequence drops mem_ss_rst_req the same instant.
- Total latency on the happy path: 1 + RST_PULSE_CYC (min) + ack delays + cal delay + STABLE_CYC cycles.

Optional Feature:
MEM_SS_CAL_RETRY_EN:
- Defined: on any FAIL condition with retry_cnt<MAX_RETRY, increment retry_cnt and return to RST_ASSERT, with the timer cleared, instead of entering FAIL. fail_code records the last cause. FAIL is entered only once retries are exhausted.
- Undefined: first error goes to FAIL directly; retry_cnt is tied to 0.

Test Plan:
- Happy path (NUM_CH=4, mask=4'b0101, RST_PULSE_CYC=16, STABLE_CYC=3): ack_n low at cycle 5, high 4 cycles after req drops, success=4'b0101 20 cycles later -> req high exactly 16 cycles, ready=1 3 cycles after success, cal_status=4'b0101, fail_code=0.
- Unmasked channel ignored: mask=4'b0011, success=4'b0011, fail=4'b1000 -> ready=1, fail=0.
- Ack timeout (ACK_TIMEOUT=64): ack_n held high -> fail=1, fail_code=1 at cycle 65 after start, mem_ss_rst_req=0.
- Stability glitch (STABLE_CYC=3, CAL_TIMEOUT=200): success for 2 cycles, drops 1, returns -> ready asserted 3 cycles after return. Success never asserted -> fail_code=2 at timer 200.
- Cal fail with retry (MEM_SS_CAL_RETRY_EN, MAX_RETRY=2): cal_fail[1] pulsed on every attempt -> 3 reset pulses observed, retry_cnt=2, fail=1, fail_code=3. Without the macro: 1 pulse, fail=1.
- Reset/start corner: rst asserted mid CAL_WAIT -> all outputs 0 immediately. start during busy -> no restart. mask=0 -> ready=1 with no reset pulse.

Source files
------------

// File: rtl/mem_ss_rst_cal_seq.sv
// Memory-subsystem reset and EMIF calibration sequencer.
// Optional macro MEM_SS_CAL_RETRY_EN: retry after errors, up to MAX_RETRY times.
module mem_ss_rst_cal_seq #(
   parameter int NUM_CH        = 4,
   parameter int RST_PULSE_CYC = 16,
   parameter int ACK_TIMEOUT   = 1024,
   parameter int CAL_TIMEOUT   = 1048576,
   parameter int STABLE_CYC    = 3,
   parameter int MAX_RETRY     = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [NUM_CH-1:0] ch_mask,
   output logic              mem_ss_rst_req,
   input  logic              mem_ss_rst_ack_n,
   input  logic [NUM_CH-1:0] mem_ss_cal_success,
   input  logic [NUM_CH-1:0] mem_ss_cal_fail,
   output logic              busy,
   output logic              ready,
   output logic              fail,
   output logic [NUM_CH-1:0] cal_status,
   output logic [1:0]        fail_code,
   output logic [1:0]        retry_cnt
);

   localparam int TMR_W = $clog2(CAL_TIMEOUT + 1);
   localparam int STB_W = (STABLE_CYC < 2) ? 1 : $clog2(STABLE_CYC + 1);

   localparam logic [TMR_W-1:0] TMR_MAX    = '1;
   localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(RST_PULSE_CYC - 1);
   localparam logic [TMR_W-1:0] ACK_TO     = TMR_W'(ACK_TIMEOUT);
   localparam logic [TMR_W-1:0] CAL_TO     = TMR_W'(CAL_TIMEOUT);
   localparam logic [STB_W-1:0] STB_DONE   = STB_W'(STABLE_CYC);

`ifdef MEM_SS_CAL_RETRY_EN
   localparam logic [1:0] RETRY_GATE = 2'b11;
`else
   localparam logic [1:0] RETRY_GATE = 2'b00;
`endif
   // A zero limit means every error is terminal.
   localparam logic [1:0] RETRY_LIM = 2'(MAX_RETRY) & RETRY_GATE;

   localparam logic [1:0] FC_NONE = 2'd0;
   localparam logic [1:0] FC_ACK  = 2'd1;
   localparam logic [1:0] FC_CTO  = 2'd2;
   localparam logic [1:0] FC_CAL  = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RST_ASSERT,
      S_RST_RELEASE,
      S_CAL_WAIT,
      S_CAL_STABLE,
      S_DONE,
      S_FAIL
   } state_t;

   state_t            state;
   logic [TMR_W-1:0]  timer;
   logic [STB_W-1:0]  stb_cnt;
   logic [NUM_CH-1:0] mask_q;

   logic [TMR_W-1:0]  tmr_inc;
   logic [STB_W-1:0]  stb_nxt;
   logic              cal_ok;
   logic              cal_bad;
   logic              pulse_ok;
   logic              err;
   logic [1:0]        err_code;

   // Saturating timer step, channel conditions and per-state error detection.
   always_comb begin
      tmr_inc  = (timer == TMR_MAX) ? timer : timer + 1'b1;
      stb_nxt  = stb_cnt + 1'b1;
      cal_ok   = ((mem_ss_cal_success & mask_q) == mask_q);
      cal_bad  = |(mem_ss_cal_fail & mask_q);
      pulse_ok = (timer >= PULSE_LAST) && !mem_ss_rst_ack_n;
      err      = 1'b0;
      err_code = FC_NONE;
      unique case (state)
         S_RST_ASSERT: begin
            if (!pulse_ok && timer >= ACK_TO) begin
               err      = 1'b1;
               err_code = FC_ACK;
            end
         end
         S_RST_RELEASE: begin
            if (!mem_ss_rst_ack_n && timer >= ACK_TO) begin
               err      = 1'b1;
               err_code = FC_ACK;
            end
         end
         S_CAL_WAIT: begin
            if (cal_bad) begin
               err      = 1'b1;
               err_code = FC_CAL;
            end else if (!cal_ok && timer >= CAL_TO) begin
               err      = 1'b1;
               err_code = FC_CTO;
            end
         end
         S_CAL_STABLE: begin
            if (cal_bad) begin
               err      = 1'b1;
               err_code = FC_CAL;
            end
         end
         default: begin
            err      = 1'b0;
            err_code = FC_NONE;
         end
      endcase
   end

   // Sequencer FSM with registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= S_IDLE;
         timer          <= '0;
         stb_cnt        <= '0;
         mask_q         <= '0;
         mem_ss_rst_req <= 1'b0;
         busy           <= 1'b0;
         ready          <= 1'b0;
         fail           <= 1'b0;
         cal_status     <= '0;
         fail_code      <= FC_NONE;
         retry_cnt      <= 2'd0;
      end else begin
         cal_status <= mem_ss_cal_success & mask_q;
         if (err) begin
            fail_code <= err_code;
            stb_cnt   <= '0;
            timer     <= '0;
            if (retry_cnt < RETRY_LIM) begin
               retry_cnt      <= retry_cnt + 2'd1;
               state          <= S_RST_ASSERT;
               mem_ss_rst_req <= 1'b1;
            end else begin
               state          <= S_FAIL;
               mem_ss_rst_req <= 1'b0;
               busy           <= 1'b0;
               fail           <= 1'b1;
            end
         end else begin
            unique case (state)
               S_IDLE, S_DONE, S_FAIL: begin
                  if (start) begin
                     mask_q    <= ch_mask;
                     fail      <= 1'b0;
                     fail_code <= FC_NONE;
                     retry_cnt <= 2'd0;
                     timer     <= '0;
                     stb_cnt   <= '0;
                     if (ch_mask == '0) begin
                        state <= S_DONE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                     end else begin
                        state          <= S_RST_ASSERT;
                        ready          <= 1'b0;
                        busy           <= 1'b1;
                        mem_ss_rst_req <= 1'b1;
                     end
                  end
               end
               S_RST_ASSERT: begin
                  if (pulse_ok) begin
                     state          <= S_RST_RELEASE;
                     mem_ss_rst_req <= 1'b0;
                     timer          <= '0;
                  end else begin
                     timer <= tmr_inc;
                  end
               end
               S_RST_RELEASE: begin
                  if (mem_ss_rst_ack_n) begin
                     state <= S_CAL_WAIT;
                     timer <= '0;
                  end else begin
                     timer <= tmr_inc;
                  end
               end
               S_CAL_WAIT: begin
                  timer <= tmr_inc;
                  if (cal_ok) begin
                     if (STABLE_CYC <= 1) begin
                        state <= S_DONE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                     end else begin
                        state   <= S_CAL_STABLE;
                        stb_cnt <= STB_W'(1);
                     end
                  end
               end
               S_CAL_STABLE: begin
                  // Timer keeps running so a glitchy channel cannot
                  // extend the overall calibration budget.
                  timer <= tmr_inc;
                  if (!cal_ok) begin
                     state <= S_CAL_WAIT;
                  end else if (stb_nxt >= STB_DONE) begin
                     state <= S_DONE;
                     ready <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     stb_cnt <= stb_nxt;
                  end
               end
               default: begin
                  state          <= S_IDLE;
                  mem_ss_rst_req <= 1'b0;
                  busy           <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mem_ss_rst_cal_seq.sv
// Directed bench for mem_ss_rst_cal_seq.
// Adapts expectations when MEM_SS_CAL_RETRY_EN is defined.
module tb_mem_ss_rst_cal_seq;

   localparam int N_ATT = `ifdef MEM_SS_CAL_RETRY_EN 3 `else 1 `endif;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] ch_mask;
   logic       req;
   logic       ack_n;
   logic [3:0] succ;
   logic [3:0] cfail;
   logic       busy;
   logic       ready;
   logic       fail;
   logic [3:0] cal_status;
   logic [1:0] fail_code;
   logic [1:0] retry_cnt;

   int n_chk  = 0;
   int n_pass = 0;
   int pulses = 0;
   int hi_cyc = 0;
   int snap_p;
   int snap_h;
   logic req_d = 1'b0;

   mem_ss_rst_cal_seq #(
      .NUM_CH        (4),
      .RST_PULSE_CYC (16),
      .ACK_TIMEOUT   (64),
      .CAL_TIMEOUT   (200),
      .STABLE_CYC    (3),
      .MAX_RETRY     (2)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .start              (start),
      .ch_mask            (ch_mask),
      .mem_ss_rst_req     (req),
      .mem_ss_rst_ack_n   (ack_n),
      .mem_ss_cal_success (succ),
      .mem_ss_cal_fail    (cfail),
      .busy               (busy),
      .ready              (ready),
      .fail               (fail),
      .cal_status         (cal_status),
      .fail_code          (fail_code),
      .retry_cnt          (retry_cnt)
   );

   always #5 clk = ~clk;

   // Count reset pulses and cycles with the request high.
   always @(negedge clk) begin
      if (req && !req_d) pulses++;
      if (req) hi_cyc++;
      req_d = req;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [3:0] m);
      ch_mask = m;
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   task automatic wait_req_lo(input string tag, input int lim);
      for (int i = 0; i < lim && req; i++) tick();
      check(tag, req, 0);
   endtask

   task automatic wait_idle(input string tag, input int lim);
      for (int i = 0; i < lim && busy; i++) tick();
      check(tag, busy, 0);
   endtask

   // Acknowledge the reset pulse, then release; ends on the CAL_WAIT entry edge.
   task automatic ack_hs();
      repeat (5) tick();
      ack_n = 1'b0;
      wait_req_lo("req_release", 64);
      repeat (4) tick();
      ack_n = 1'b1;
      tick();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; ch_mask = '0;
      ack_n = 1'b1; succ = '0; cfail = '0;
      repeat (2) tick();
      check("rst_busy", busy, 0);
      check("rst_ready", ready, 0);
      check("rst_fail", fail, 0);
      check("rst_req", req, 0);
      check("rst_code", fail_code, 0);
      check("rst_retry", retry_cnt, 0);
      check("rst_status", cal_status, 0);
      rst = 1'b0;
      tick();

      // Happy path
      snap_h = hi_cyc;
      do_start(4'b0101);
      check("hp_busy", busy, 1);
      check("hp_req", req, 1);
      ack_hs();
      check("hp_req_cycles", hi_cyc - snap_h, 16);
      repeat (19) tick();
      succ = 4'b0101;
      repeat (2) tick();
      check("hp_ready_early", ready, 0);
      tick();
      check("hp_ready", ready, 1);
      check("hp_busy_done", busy, 0);
      check("hp_status", cal_status, 4'b0101);
      check("hp_code", fail_code, 0);
      check("hp_fail", fail, 0);

      // Unmasked channel failing is ignored
      succ = 4'b0011; cfail = 4'b1000;
      do_start(4'b0011);
      ack_hs();
      wait_idle("um_idle", 20);
      check("um_ready", ready, 1);
      check("um_fail", fail, 0);
      check("um_status", cal_status, 4'b0011);

      // Ack timeout
      succ = '0; cfail = '0;
      do_start(4'b0001);
      repeat (64) tick();
      check("ato_fail_early", fail, 0);
      check("ato_req_early", req, 1);
      tick();
`ifdef MEM_SS_CAL_RETRY_EN
      check("ato_retry1", retry_cnt, 1);
      check("ato_busy_retry", busy, 1);
      wait_idle("ato_idle", 300);
      check("ato_retry2", retry_cnt, 2);
`endif
      check("ato_fail", fail, 1);
      check("ato_code", fail_code, 1);
      check("ato_req", req, 0);
      check("ato_busy", busy, 0);

      // Stability glitch
      do_start(4'b1111);
      ack_hs();
      succ = 4'b1111;
      repeat (2) tick();
      succ = 4'b0000;
      tick();
      check("gl_ready_drop", ready, 0);
      check("gl_busy_drop", busy, 1);
      succ = 4'b1111;
      repeat (2) tick();
      check("gl_ready_early", ready, 0);
      tick();
      check("gl_ready", ready, 1);

      // Calibration timeout
      succ = '0;
      do_start(4'b0001);
      ack_hs();
      repeat (200) tick();
      check("cto_fail_early", fail, 0);
      check("cto_code_early", fail_code, 0);
      tick();
      check("cto_code", fail_code, 2);
`ifdef MEM_SS_CAL_RETRY_EN
      check("cto_retry", retry_cnt, 1);
      check("cto_fail", fail, 0);
`else
      check("cto_fail", fail, 1);
`endif
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();

      // Calibration failure, fail wins over success
      succ = 4'b0011; cfail = 4'b0010;
      snap_p = pulses;
      do_start(4'b0011);
      for (int a = 0; a < N_ATT; a++) begin
         ack_hs();
         tick();
      end
      check("cf_fail", fail, 1);
      check("cf_code", fail_code, 3);
      check("cf_retry", retry_cnt, 2'(N_ATT - 1));
      check("cf_pulses", pulses - snap_p, N_ATT);
      check("cf_ready", ready, 0);

      // Start while busy, then async reset in CAL_WAIT
      succ = '0; cfail = '0;
      do_start(4'b0011);
      ack_hs();
      check("bz_busy", busy, 1);
      do_start(4'b0000);
      check("bz_ignored_busy", busy, 1);
      check("bz_ignored_ready", ready, 0);
      #2 rst = 1'b1;
      #1;
      check("ar_busy", busy, 0);
      check("ar_ready", ready, 0);
      check("ar_fail", fail, 0);
      rst = 1'b0;
      tick();

      // Async reset drops the request immediately
      do_start(4'b0001);
      repeat (3) tick();
      check("ar_req_hi", req, 1);
      #2 rst = 1'b1;
      #1;
      check("ar_req_lo", req, 0);
      rst = 1'b0;
      tick();

      // Empty mask
      snap_p = pulses;
      do_start(4'b0000);
      check("m0_ready", ready, 1);
      check("m0_busy", busy, 0);
      repeat (3) tick();
      check("m0_pulses", pulses - snap_p, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
